shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one external storage register (a `WIDTH`-bit D flip-flop bank with load enable) among `N_REQ` requesters. It grants exclusive ownership to one requester at a time and steers that requester's write data and load strobe onto the register. It returns the register's output to the owner as read data and enforces a burst limit so that no requester can starve the others. It sits between requester logic and the flop bank, and is the only driver of that bank's `d` and load inputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, register data width
- `MAX_BURST`, 3, maximum consecutive owned cycles while another requester waits (>=1)

- `clk`  in  1  clock; all state updates on posedge
- `rst_l`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester access request; held high for as long as access is wanted
- `wr`  in  N_REQ  per-requester access type: 1 = write, 0 = read
- `wdata`  in  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- `gnt`  out  N_REQ  one-hot-or-zero ownership, registered
- `rdata`  out  WIDTH  equals `reg_q`
- `rvalid`  out  1  owner is performing a read this cycle
- `reg_d`  out  WIDTH  data to the storage register
- `reg_ld`  out  1  load strobe to the storage register
- `reg_q`  in  WIDTH  storage register output
- `busy`  out  1  high whenever `gnt` != 0

## Operation
- States: IDLE (no owner) and OWN (one owner held in `gnt`). `owner` is the index of the set bit of `gnt`.
- Pointer `last` holds the index of the most recent owner. The picker selects the first requester with `req` high, searching from `last+1` and wrapping modulo `N_REQ`.
- IDLE: if any `req` is high, then at the next edge `gnt` = the picked requester, `cnt` = 1, `last` = that requester, and the state becomes OWN. Otherwise the block stays in IDLE.
- OWN, at each edge:
  - If `req[owner]` is low (release), re-pick excluding the owner. If there is a winner, grant it directly with no bubble and set `cnt` = 1. If not, `gnt` = 0 and the state becomes IDLE.
  - Else, if `cnt` == `MAX_BURST` and some other `req` is high (preempt), grant the next requester in round-robin order and set `cnt` = 1.
  - Else the owner keeps the grant and `cnt` increments, saturating at `MAX_BURST`.
- Access is performed in any cycle where `gnt[i]` & `req[i]` is high:
  - Write: `reg_ld` = 1 and `reg_d` = `wdata[i]`.
  - Read: `rvalid` = 1 and `rdata` = `reg_q`.
- `reg_ld`, `reg_d` and `rvalid` are combinational from the registered `gnt` and the inputs. When no access is performed, `reg_ld` = 0 and `reg_d` = 0.
- A lone requester is never preempted: `cnt` saturates and it keeps the grant indefinitely.
- Simultaneous release by the owner and a new request elsewhere: the new requester is granted at that same edge.
- Reset (asynchronous, mid-operation allowed) sets `gnt` = 0, state = IDLE, `cnt` = 0 and `last` = `N_REQ`-1, so requester 0 has first priority. An in-flight write is dropped because `reg_ld` falls immediately. The contents of the register itself are outside this block's control.

## Timing
- Latency from request to grant: `req[i]` rising in cycle n gives `gnt[i]` high in cycle n+1 when the resource is free. The first access happens in cycle n+1.
- Release: `req[owner]` low in cycle n gives `gnt[owner]` low in cycle n+1. A waiting requester is granted in cycle n+1.
- Read data: `reg_q` reflects a write performed in cycle n from cycle n+1 onward. A read in the same cycle as a write returns the old value (not possible within one requester).
- Worst-case wait for a continuously requesting requester: (`N_REQ`-1)*`MAX_BURST` cycles plus 1.
- Reset values: `gnt` = 0, `busy` = 0, `reg_ld` = 0, `reg_d` = 0, `rvalid` = 0. `rdata` follows `reg_q`.

## Structure
- Package `shared_reg_pkg` holds:
  - the state enum `arb_state_t` {IDLE, OWN};
  - default constants `N_REQ_DEF`, `WIDTH_DEF`, `MAX_BURST_DEF`.
- Sub-module `rr_pick` is a combinational round-robin picker. Inputs: `req` vector, `last` index and an exclude mask. Outputs: a found flag and the winner index. It is instantiated once.
- The top level contains the FSM, `cnt`, `last`, the `gnt` register and the output steering mux.

## Test plan
- **Reset and single write:** release `rst_l`, drive `req[2]` = 1, `wr[2]` = 1, `wdata[2]` = 8'hA5.
  - `gnt` = 4'b0100 one cycle later, with `reg_ld` = 1 and `reg_d` = 8'hA5.
  - Then drop `req[2]`, drive `req[0]` = 1 with `wr` = 0: read returns `rdata` = 8'hA5 with `rvalid` = 1.
- **Round-robin with all four requesting:**
  - With all four `req` held from reset, the grant order is 0,1,2,3,0.
  - Each requester holds `gnt` for exactly 3 cycles (`MAX_BURST` = 3) and there are no idle cycles between grants.
- **Lone requester:** `req[1]` held for 20 cycles.
  - `gnt` = 4'b0010 throughout and `busy` = 1.
  - `gnt` = 0 one cycle after `req[1]` falls.
- **Early release handoff:** owner 0 drops `req` after 1 cycle while `req[3]` is waiting.
  - `gnt` goes from 4'b0001 to 4'b1000 at the next edge, with no IDLE cycle.
- **Reset mid-write:** assert `rst_l` = 0 asynchronously in the middle of a cycle while `reg_ld` = 1.
  - `gnt`, `reg_ld` and `busy` go to 0 immediately.
  - After release, requester 0 wins over requester 3 when both request together.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// -----------------------------------------------------------------------------
// shared_reg_pkg
// Shared types and default parameters for the shared-register arbiter.
//   arb_state_t   : arbiter FSM state (IDLE = no owner, OWN = one owner)
//   *_DEF         : default values for the arbiter parameters
// -----------------------------------------------------------------------------
package shared_reg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int WIDTH_DEF     = 8;
  localparam int MAX_BURST_DEF = 3;

endpackage : shared_reg_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first requester with its
// request bit set (and not excluded), searching from last_i+1 and wrapping
// modulo N_REQ. last_i itself is the final candidate considered.
// Ports:
//   req_i    [N_REQ-1:0]  request vector
//   last_i   [IDX_W-1:0]  index of the most recent owner
//   excl_i   [N_REQ-1:0]  requesters that may not win this pick
//   found_o               a winner exists
//   winner_o [IDX_W-1:0]  index of the winner (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic             found_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [N_REQ-1:0] cand;

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    cand     = req_i & ~excl_i;
    // Offsets 1..N_REQ visit every index once, starting just after last_i.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_i) + k) % N_REQ;
      if (!found_o && cand[idx]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule : rr_pick

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin owner of one external WIDTH-bit storage register shared by
// N_REQ requesters. The owner's write data and load strobe are steered onto
// the register; the register output is returned as read data. An owner that
// has held the grant for MAX_BURST cycles is preempted when anyone else waits.
// Ports:
//   clk, rst_l         clock, asynchronous active-low reset
//   req   [N_REQ]      per-requester request (held while access is wanted)
//   wr    [N_REQ]      per-requester access type, 1 = write, 0 = read
//   wdata [N_REQ*W]    write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   [N_REQ]      registered one-hot-or-zero ownership
//   rdata [W]          register contents (reg_q passed through)
//   rvalid             owner is reading this cycle
//   reg_d [W], reg_ld  data and load strobe to the storage register
//   reg_q [W]          storage register output
//   busy               some requester owns the register
// -----------------------------------------------------------------------------
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       wr,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   reg_ld,
  input  logic [WIDTH-1:0]       reg_q,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [N_REQ-1:0] excl;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             at_limit;
  logic             take;
  logic             access;

  // While owning, last_q is the owner; it must not re-win its own hand-off.
  always_comb begin
    excl = '0;
    if (state_q == OWN) excl[last_q] = 1'b1;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .excl_i   (excl),
    .found_o  (pick_found),
    .winner_o (pick_idx)
  );

  assign owner_req = req[last_q];
  assign at_limit  = (cnt_q == CNT_W'(MAX_BURST));
  // A new owner is taken when free, on release, or on preemption at the limit.
  assign take      = pick_found && (state_q == IDLE || !owner_req || at_limit);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      OWN: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (!at_limit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Overrides the release/keep path so a waiting requester is granted at
    // the same edge with no idle bubble.
    if (take) begin
      state_d = OWN;
      gnt_d   = N_REQ'(1) << pick_idx;
      cnt_d   = CNT_W'(1);
      last_d  = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Steering is combinational from the registered grant, so reset drops an
  // in-flight load strobe immediately.
  assign busy   = |gnt_q;
  assign access = busy & owner_req;
  assign reg_ld = access & wr[last_q];
  assign reg_d  = reg_ld ? wdata[int'(last_q)*WIDTH +: WIDTH] : '0;
  assign rvalid = access & ~wr[last_q];
  assign rdata  = reg_q;
  assign gnt    = gnt_q;

endmodule : shared_reg_arbiter

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=3).
// A behavioural model predicts every cycle's outputs; predictions are queued
// when inputs are driven and popped when outputs are sampled. A vector table
// and hand-written sequences add fixed expectations for the key scenarios.
// The external storage register is modelled here as a plain flop bank.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 3;

  logic           clk = 1'b0;
  logic           rst_l;
  logic [N-1:0]   req, wr, gnt;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   rdata, reg_d;
  logic [W-1:0]   reg_q = '0;
  logic           rvalid, reg_ld, busy;

  int total = 0;
  int bad   = 0;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .req    (req),
    .wr     (wr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rdata  (rdata),
    .rvalid (rvalid),
    .reg_d  (reg_d),
    .reg_ld (reg_ld),
    .reg_q  (reg_q),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // External storage register.
  always @(posedge clk) if (reg_ld) reg_q <= reg_d;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0] gnt;
    logic         busy;
    logic         ld;
    logic [W-1:0] d;
    logic         rv;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   wr;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           ld;
    logic [W-1:0]   d;
    logic           rv;
    logic [W-1:0]   rdata;
  } vec_t;

  exp_t sb_q[$];

  // Reference model state.
  int           m_owner;  // -1 when nobody owns
  int           m_cnt;
  int           m_last;
  logic [W-1:0] m_mem = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t o;
    logic acc;
    o.gnt   = '0;
    acc     = 1'b0;
    if (m_owner >= 0) begin
      o.gnt[m_owner] = 1'b1;
      acc = req[m_owner];
    end
    o.busy  = (m_owner >= 0);
    o.ld    = acc && wr[m_owner];
    o.d     = o.ld ? wdata[m_owner*W +: W] : '0;
    o.rv    = acc && !wr[m_owner];
    o.rdata = m_mem;
    return o;
  endfunction

  function automatic int pick(input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = N - 1;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_cnt   = 1;
    m_last  = w;
  endtask

  task automatic model_edge();
    exp_t o;
    int   w;
    o = model_out();
    if (o.ld) m_mem = o.d;
    if (m_owner < 0) begin
      w = pick(-1);
      if (w >= 0) model_grant(w);
    end else if (!req[m_owner]) begin
      w = pick(m_owner);
      if (w >= 0) model_grant(w);
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else begin
      w = pick(m_owner);
      if (m_cnt == MB && w >= 0) model_grant(w);
      else if (m_cnt < MB) m_cnt++;
    end
  endtask

  // Drive inputs mid-cycle, queue the prediction, settle before sampling.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w,
                       input logic [N*W-1:0] wd);
    @(negedge clk);
    req   = r;
    wr    = w;
    wdata = wd;
    sb_q.push_back(model_out());
    #1;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s.queue: got empty expected an entry", tag);
      return;
    end
    total--;
    e = sb_q.pop_front();
    check({tag, ".gnt"},    32'(gnt),    32'(e.gnt));
    check({tag, ".busy"},   32'(busy),   32'(e.busy));
    check({tag, ".reg_ld"}, 32'(reg_ld), 32'(e.ld));
    check({tag, ".reg_d"},  32'(reg_d),  32'(e.d));
    check({tag, ".rvalid"}, 32'(rvalid), 32'(e.rv));
    check({tag, ".rdata"},  32'(rdata),  32'(e.rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    req   = '0;
    wr    = '0;
    wdata = '0;
    #1;
    check("rst.gnt",    32'(gnt),    32'h0);
    check("rst.busy",   32'(busy),   32'h0);
    check("rst.reg_ld", 32'(reg_ld), 32'h0);
    check("rst.reg_d",  32'(reg_d),  32'h0);
    check("rst.rvalid", 32'(rvalid), 32'h0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    tick();
  endtask

  vec_t tbl [7];
  logic [N-1:0] rr_exp [14] = '{4'b0000,
                                4'b0001, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0010,
                                4'b0100, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b1000,
                                4'b0001};

  initial begin
    logic [N-1:0] r;

    rst_l = 1'b0;
    req   = '0;
    wr    = '0;
    wdata = '0;
    model_reset();

    // req, wr, wdata, gnt, reg_ld, reg_d, rvalid, rdata
    tbl[0] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 4'b0100, 32'h00A5_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{4'b0100, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[3] = '{4'b0001, 4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[4] = '{4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 1'b0, 8'h00, 1'b1, 8'hA5};
    tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0001, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[6] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'hA5};

    // Reset, single write, then read-back by requester 0.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].req, tbl[i].wr, tbl[i].wdata);
      sb_check("tbl_sb");
      check($sformatf("tbl%0d.gnt", i),    32'(gnt),    32'(tbl[i].gnt));
      check($sformatf("tbl%0d.reg_ld", i), 32'(reg_ld), 32'(tbl[i].ld));
      check($sformatf("tbl%0d.reg_d", i),  32'(reg_d),  32'(tbl[i].d));
      check($sformatf("tbl%0d.rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      check($sformatf("tbl%0d.rdata", i),  32'(rdata),  32'(tbl[i].rdata));
      tick();
    end

    // All four requesting: 0,1,2,3,0, three cycles each, no gaps.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(4'b1111, 4'b0101, 32'hD4C3_B2A1);
      sb_check("rr");
      check($sformatf("rr_order%0d", c), 32'(gnt), 32'(rr_exp[c]));
      tick();
    end

    // Lone requester is never preempted.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010, 4'($urandom), $urandom);
      sb_check("lone");
      if (c > 0) begin
        check("lone.gnt",  32'(gnt),  32'b0010);
        check("lone.busy", 32'(busy), 32'h1);
      end
      tick();
    end
    drive(4'b0000, 4'b0000, '0);
    sb_check("lone_drop");
    tick();
    drive(4'b0000, 4'b0000, '0);
    sb_check("lone_idle");
    check("lone_release.gnt", 32'(gnt), 32'h0);
    tick();

    // Early release by owner 0 hands straight over to waiting requester 3.
    do_reset();
    drive(4'b0001, 4'b0000, '0);
    sb_check("early");
    tick();
    drive(4'b1001, 4'b0000, '0);
    sb_check("early");
    check("early.own0", 32'(gnt), 32'b0001);
    tick();
    drive(4'b1000, 4'b0000, '0);
    sb_check("early");
    check("early.rel", 32'(gnt), 32'b0001);
    tick();
    drive(4'b1000, 4'b1000, 32'h7700_0000);
    sb_check("early");
    check("handoff.gnt",  32'(gnt),  32'b1000);
    check("handoff.busy", 32'(busy), 32'h1);
    tick();

    // Random traffic with sticky requests to exercise bursts and preemption.
    for (int c = 0; c < 200; c++) begin
      r = req ^ (4'($urandom) & 4'($urandom));
      drive(r, 4'($urandom), $urandom);
      sb_check("rand");
      tick();
    end

    // Asynchronous reset in the middle of a write cycle.
    do_reset();
    drive(4'b0001, 4'b0001, 32'h0000_003C);
    sb_check("midrst");
    tick();
    drive(4'b0001, 4'b0001, 32'h0000_003C);
    sb_check("midrst");
    #2;
    check("midrst.ld_before", 32'(reg_ld), 32'h1);
    rst_l = 1'b0;
    #1;
    check("midrst.gnt",    32'(gnt),    32'h0);
    check("midrst.reg_ld", 32'(reg_ld), 32'h0);
    check("midrst.busy",   32'(busy),   32'h0);
    check("midrst.reg_d",  32'(reg_d),  32'h0);
    req = '0;
    wr  = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    drive(4'b1001, 4'b0000, '0);
    sb_check("postrst");
    check("postrst.idle", 32'(gnt), 32'h0);
    tick();
    drive(4'b1001, 4'b0000, '0);
    sb_check("postrst");
    check("postrst.prio0", 32'(gnt), 32'b0001);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shared_reg_arbiter
